xdivux8: RTL

Sequential unsigned divider, the inverse companion to the team's 8-bit unsigned multiplier block. Shares the same operand-loading front end: one 8-bit input bus written into dividend and divisor registers by separate apply strobes. A restoring shift-subtract datapath produces quotient and remainder one bit per clock. Used by the experiment top level wherever an operand pair must be divided rather than multiplied.

---
 rtl/xdivux8.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/xdivux8.sv
// xdivux8 - sequential unsigned divider (restoring shift-subtract, one quotient bit per clock).
//
// Shares the operand-loading front end of the companion multiplier: a single data bus written
// into the dividend/divisor registers by independent apply strobes while idle.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous, active-high reset
//   in_i         operand data bus (WIDTH)
//   a_apply_i    load dividend register from in_i (idle only)
//   b_apply_i    load divisor register from in_i (idle only)
//   start_i      begin division of the current register contents (idle only)
//   quotient_o   last quotient; held until the next result
//   remainder_o  last remainder; held until the next result
//   busy_o       high while iterating
//   done_o       one-cycle pulse when a new result is presented
//   div_zero_o   last result came from a zero divisor
module xdivux8 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic             a_apply_i,
    input  logic             b_apply_i,
    input  logic             start_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    // StZero spends one idle-looking cycle before DONE so a zero-divisor result appears
    // one cycle after the start edge, with busy never raised.
    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StZero,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] wq_q, wq_d;      // working quotient (starts as the dividend)
    logic [WIDTH:0]   pr_q, pr_d;      // partial remainder, one guard bit
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;

    logic [2*WIDTH:0] shift_full;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] wq_shifted;
    logic [WIDTH+1:0] trial;

    // Shift {remainder, quotient} left and try subtracting the divisor; the extra top bit
    // of trial is the borrow that decides restore versus keep.
    always_comb begin
        shift_full = {pr_q, wq_q} << 1;
        shifted    = shift_full[2*WIDTH:WIDTH];
        wq_shifted = shift_full[WIDTH-1:0];
        trial      = {1'b0, shifted} - {2'b00, b_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        wq_d    = wq_q;
        pr_d    = pr_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;

        unique case (state_q)
            StIdle: begin
                if (a_apply_i) a_d = in_i;
                if (b_apply_i) b_d = in_i;
                // start sees the register values from before this edge
                if (start_i) begin
                    if (b_q != '0) begin
                        state_d = StRun;
                        wq_d    = a_q;
                        pr_d    = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = StZero;
                        wq_d    = a_q;
                    end
                end
            end
            StRun: begin
                if (!trial[WIDTH+1]) begin
                    pr_d = trial[WIDTH:0];
                    wq_d = wq_shifted | WIDTH'(1);
                end else begin
                    pr_d = shifted;
                    wq_d = wq_shifted;
                end
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    quot_d  = wq_d;
                    rem_d   = pr_d[WIDTH-1:0];
                    dz_d    = 1'b0;
                    state_d = StDone;
                end
            end
            StZero: begin
                quot_d  = '1;
                rem_d   = wq_q;
                dz_d    = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            wq_q    <= '0;
            pr_q    <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            wq_q    <= wq_d;
            pr_q    <= pr_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;
    assign div_zero_o  = dz_q;
    assign busy_o      = (state_q == StRun);
    assign done_o      = (state_q == StDone);

endmodule
